fifo_ram_ctrl: RTL
==================

Name: fifo_ram_ctrl

Overview:
- Initiator side of the dual-port FIFO RAM interface: owns write/read pointers and occupancy, and drives the RAM's state, enable, address and write-data lines.
- Accepts push/pop requests from the surrounding switch logic, registers read data from the RAM's combinational read port, and reports full/empty/threshold/error status.
- One instance per FIFO; paired 1:1 with a RAM of matching RAM_WIDTH/ADDR_SIZE.

Parameters:
- RAM_WIDTH, 4, data word width.
- ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE (8 by default).
- ALMOST_FULL_TH, 6, almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  write request, data on data_in.
- pop  in  1  read request.
- data_in  in  RAM_WIDTH  word to store.
- ram_rdata  in  RAM_WIDTH  RAM combinational read data.
- ram_state  out  2  to RAM: 0 idle, 1 read, 2 write, 3 read+write.
- ram_enable  out  1  to RAM read enable; equals ram_state[0].
- ram_addr_in  out  ADDR_SIZE  RAM write address (= wr_ptr).
- ram_addr_out  out  ADDR_SIZE  RAM read address (= rd_ptr).
- ram_wdata  out  RAM_WIDTH  equals data_in.
- data_out  out  RAM_WIDTH  registered popped word.
- valid_out  out  1  data_out holds a word popped last cycle.
- count  out  ADDR_SIZE+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1  status flags.
- overflow, underflow  out  1  error flags.

Behaviour:
- Reset (async, reset_L=0): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0. Flags follow count, so empty=1, almost_empty=1, full=0, almost_full=0. Combinational RAM outputs are 0 while reset_L=0.
- Accepts:
  - push_ok = push & (~full | pop_ok).
  - pop_ok = pop & ~empty.
  - Push into an empty FIFO is never bypassed to the read side in the same cycle.
- RAM drive (combinational):
  - ram_state = {push_ok, pop_ok}.
  - ram_addr_in = wr_ptr; ram_addr_out = rd_ptr.
  - The RAM writes on the same posedge that advances wr_ptr.
- Clock edge:
  - push_ok: wr_ptr += 1, wrapping modulo DEPTH.
  - pop_ok: rd_ptr += 1 (wrap), data_out <= ram_rdata, valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
  - count += push_ok - pop_ok. Simultaneous push_ok and pop_ok leaves count unchanged.
- Pop latency: 1 cycle, pop at edge N gives data_out/valid_out after edge N.
- Flags are decoded from the count register only, with no combinational path from push/pop:
  - full = (count == DEPTH); empty = (count == 0).
  - almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH).
- Full with push and pop together: both are accepted and count stays DEPTH.
- Empty with push and pop together: push accepted, pop rejected (underflow), count becomes 1.
- Rejected push: at full without pop. Asserts the overflow condition; no pointer or RAM change.
- Rejected pop: at empty. Asserts the underflow condition; data_out is held and valid_out=0.
- Error flag timing is defined under Optional Feature.
- Reset mid-operation: all state clears immediately and asynchronously, and RAM contents are not relied upon afterwards.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: overflow/underflow are sticky. They set on the edge after the first rejected request and clear only on reset_L=0.
- Undefined: overflow/underflow pulse high for exactly one cycle, on the edge after each rejected request.

Test Plan:
- Reset, then push 0x1,0x2,0x3 on consecutive cycles, then pop 3 cycles -> data_out 0x1,0x2,0x3, each one cycle after its pop; count 0, empty=1.
- Push 8 words 0x0..0x7 -> count=8, full=1, almost_full set once count reaches 6. A 9th push -> overflow asserted, count stays 8, and the next pops return 0x0 first.
- Fill to 8, then push 0xA with pop simultaneously -> data_out=0x0, count=8; after 8 more pops the last word is 0xA, verifying wr/rd pointer wrap.
- Empty FIFO with push 0x5 and pop together -> underflow asserted, valid_out=0, count=1; the next pop returns 0x5.
- Assert reset_L=0 mid-cycle with count=4 -> all outputs reset immediately without a clock edge; after release, empty=1 and ram_state=0.
- Error flag behaviour, with and without FIFO_ERR_STICKY_EN: two separated underflows. Defined -> underflow stays 1 until reset. Undefined -> two distinct one-cycle pulses.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: initiator-side controller for a dual-port FIFO RAM.
// It owns the write/read pointers and the occupancy count, and drives the RAM
// control, address and write-data lines. Read data is registered from the RAM's
// combinational read port, so a pop has a latency of one cycle.
// Optional feature macro: FIFO_ERR_STICKY_EN. When it is defined, overflow and
// underflow stay set until reset. When it is undefined, each one pulses for a
// single cycle.
module fifo_ram_ctrl #(
  parameter int unsigned RAM_WIDTH       = 4,
  parameter int unsigned ADDR_SIZE       = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [RAM_WIDTH-1:0] data_in,
  input  logic [RAM_WIDTH-1:0] ram_rdata,
  output logic [1:0]           ram_state,
  output logic                 ram_enable,
  output logic [ADDR_SIZE-1:0] ram_addr_in,
  output logic [ADDR_SIZE-1:0] ram_addr_out,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  localparam logic [ADDR_SIZE:0] CountFull = CW'(DEPTH);
  localparam logic [ADDR_SIZE:0] AfTh      = CW'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AeTh      = CW'(ALMOST_EMPTY_TH);

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [RAM_WIDTH-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic push_ok, pop_ok, push_rej, pop_rej;

  // The status flags decode only the registered count, so push and pop have no
  // combinational path to them.
  always_comb begin
    full         = (count_q == CountFull);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfTh);
    almost_empty = (count_q <= AeTh);
  end

  // Accept decode. A push into a full FIFO is allowed when a pop frees a slot in
  // the same cycle. A push into an empty FIFO is never bypassed to the read side.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    push_rej = push & ~push_ok;
    pop_rej  = pop & ~pop_ok;
  end

  // RAM drive. While reset is asserted the drive is forced to zero so that no
  // write happens and the lines are quiet.
  always_comb begin
    ram_state    = reset_L ? {push_ok, pop_ok} : 2'b00;
    ram_enable   = ram_state[0];
    ram_addr_in  = reset_L ? wr_ptr_q : '0;
    ram_addr_out = reset_L ? rd_ptr_q : '0;
    ram_wdata    = reset_L ? data_in : '0;
  end

  // Next-state computation for the pointers, the count, read data and the error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(1);
      data_out_d = ram_rdata;
      valid_d    = 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    overflow_d  = overflow_q | push_rej;
    underflow_d = underflow_q | pop_rej;
`else
    overflow_d  = push_rej;
    underflow_d = pop_rej;
`endif
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
